race_tree_sequencer: RTL
========================

Name: race_tree_sequencer

Overview:
- Two-lane drag-race start controller.
- Sequences the red/yellow/green light tree and counts down the amber stages.
- Flags a lane that leaves the line before green as a foul, times each lane from green to finish, and declares the winner.
- Sits between the lane sensors and the light-tree drivers; it replaces ad-hoc light-tree sequencing with one synchronous Moore controller.

Parameters:
- YELLOW_CYCLES, 4: clock cycles each amber stage is lit (>=1).
- NUM_AMBER, 3: number of amber stages before green (1..3).
- TIMER_W, 16: width of each elapsed-time counter.
- TIMEOUT_CYCLES, 1000: maximum race length in cycles after green (< 2^TIMER_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  arm/clear request, level-sampled.
- staged  in  2  per-lane staging beam, 1 = vehicle on line; bit0 = lane 0.
- finish  in  2  per-lane finish beam, 1 = vehicle crossed.
- red  out  1  red lamp.
- yellow  out  1  amber lamp.
- green  out  1  green lamp.
- amber_idx  out  2  current amber stage 1..NUM_AMBER; 0 outside AMBER.
- foul  out  2  per-lane foul flag, latched.
- winner  out  2  one-hot winner; 2'b11 = tie; 2'b00 = none.
- done  out  1  result valid.
- et0  out  TIMER_W  lane 0 elapsed cycles, green to finish.
- et1  out  TIMER_W  lane 1 elapsed cycles, green to finish.

Behaviour:
- Reset:
  - Reset is asynchronous, active-low, on reset_n; single clock clk.
  - While reset_n=0: state=IDLE, red=1, and yellow, green, amber_idx, foul, winner, done, et0 and et1 are all 0.
  - Reset asserted in any state aborts immediately.
- Implementation: all state is flip-flops (no latches); lamp outputs are decoded from the registered state only.
- States: IDLE, AMBER, RUN, RESULT.
- IDLE (red=1):
  - If start=1 and staged=2'b11 on a clock edge: go to AMBER. yellow=1 and amber_idx=1 from the next cycle; the stage counter is cleared.
  - start with either lane unstaged is ignored.
- AMBER (yellow=1):
  - The stage counter advances every cycle; amber_idx increments after each YELLOW_CYCLES cycles.
  - After exactly NUM_AMBER*YELLOW_CYCLES AMBER cycles: go to RUN, with green=1 on the following cycle.
  - Foul rule: staged[i] sampled 0 in any AMBER cycle sets foul[i]=1. foul stays set until leaving RESULT; re-staging does not clear it.
  - Both lanes fouled: go to RESULT directly with winner=00, et0=et1=0.
- RUN (green=1):
  - et0 and et1 are 0 on the first RUN cycle.
  - Each non-fouled, unfinished lane's et increments by 1 per cycle.
  - finish[i] sampled 1 freezes et[i] at its current value. Fouled lanes' et stays 0 and their finish is ignored.
  - Winner: the first non-fouled lane to finish sets winner to its one-hot bit. Both finishing on the same cycle gives winner=11. winner is not changed afterwards.
  - Go to RESULT when every non-fouled lane has finished, or when any active et reaches TIMEOUT_CYCLES.
  - On timeout, unfinished lanes' et holds TIMEOUT_CYCLES. winner stays 00 if nobody finished.
  - staged is ignored in RUN.
- RESULT (red=1, done=1):
  - All results are held.
  - start=1 on a clock edge: go to IDLE and clear foul, winner, done, et0 and et1.
  - start must have been observed 0 at least once inside RESULT before it is accepted. This prevents a held start button from clearing results immediately.
- Exactly one of red, yellow, green is 1 at any time.
- Latency: start accepted at edge n gives yellow at n+1 and green at n+1+NUM_AMBER*YELLOW_CYCLES. With the defaults, green follows 12 cycles after yellow.
- Simultaneous events: a foul and the last amber cycle on the same edge still records the foul. A finish on the same cycle as the timeout counts as a finish.

Test Plan:
- Clean race (defaults): stage both, pulse start. Yellow for 12 cycles with amber_idx 1,2,3 (4 cycles each), then green. finish0 at RUN cycle 50, finish1 at cycle 57 → winner=01, et0=50, et1=57, done=1.
- Foul: lane1 drops staged at amber_idx=2 → foul=10, green still occurs. finish0 at cycle 30 → winner=01, et0=30, et1=0.
- Double foul: both lanes drop staged during AMBER → RESULT on the next cycle, red=1, foul=11, winner=00, no green ever.
- Tie and timeout: both finish on RUN cycle 20 → winner=11, et0=et1=20. Separately, no finish → RESULT with et0=et1=1000, winner=00.
- Start gating: start with staged=01 → stays IDLE, red=1. Hold start through RESULT → results held until start goes 0 and then 1, after which IDLE is entered with outputs cleared.
- Async reset mid-AMBER and mid-RUN: reset_n low between clock edges → red=1 and all other outputs 0 immediately. After release, a normal race reproduces the clean-race results.

Source files
------------

// File: rtl/race_tree_if.sv
// Lane-sensor and light-tree signal bundle for the two-lane race start controller.
// The slave side is the controller; the master side is whatever drives the sensors.
interface race_tree_if #(
  parameter int TIMER_W = 16
);
  logic               start;
  logic [1:0]         staged;
  logic [1:0]         finish;
  logic               red;
  logic               yellow;
  logic               green;
  logic [1:0]         amber_idx;
  logic [1:0]         foul;
  logic [1:0]         winner;
  logic               done;
  logic [TIMER_W-1:0] et0;
  logic [TIMER_W-1:0] et1;

  modport slave (
    input  start, staged, finish,
    output red, yellow, green, amber_idx, foul, winner, done, et0, et1
  );

  modport master (
    output start, staged, finish,
    input  red, yellow, green, amber_idx, foul, winner, done, et0, et1
  );
endinterface

// File: rtl/race_tree_sequencer.sv
// Two-lane drag-race start controller: sequences the light tree, latches fouls,
// times each lane from green to finish and declares the winner (Moore outputs).
module race_tree_sequencer #(
  parameter int YELLOW_CYCLES  = 4,
  parameter int NUM_AMBER      = 3,
  parameter int TIMER_W        = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic        clk,
  input logic        reset_n,
  race_tree_if.slave bus
);
  localparam int                 YCW    = $clog2(YELLOW_CYCLES) + 1;
  localparam logic [YCW-1:0]     Y_LAST = YCW'(YELLOW_CYCLES - 1);
  localparam logic [1:0]         A_LAST = 2'(NUM_AMBER);
  localparam logic [TIMER_W-1:0] T_MAX  = TIMER_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, AMBER, RUN, RESULT} state_t;

  state_t             state_reg, state_next;
  logic [YCW-1:0]     ycnt_reg, ycnt_next;
  logic [1:0]         amber_idx_reg, amber_idx_next;
  logic [1:0]         foul_reg, foul_next;
  logic [1:0]         winner_reg, winner_next;
  logic [1:0]         fin_reg, fin_next;
  logic               seen_low_reg, seen_low_next;
  logic [TIMER_W-1:0] et_reg  [2];
  logic [TIMER_W-1:0] et_next [2];
  logic [1:0]         fin_hit;
  logic [1:0]         tmo_hit;
  logic               clear_results;

  // A start held over from arming must be released once inside RESULT before it clears.
  assign clear_results = (state_reg == RESULT) && bus.start && seen_low_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic running;

      assign running      = (state_reg == RUN) && !foul_reg[gi] && !fin_reg[gi];
      assign fin_hit[gi]  = running && bus.finish[gi];
      assign tmo_hit[gi]  = running && !bus.finish[gi] && (et_reg[gi] == T_MAX);
      assign fin_next[gi] = clear_results ? 1'b0 : (fin_reg[gi] | fin_hit[gi]);
      assign et_next[gi]  = clear_results ? '0 :
                            (running && !bus.finish[gi] && (et_reg[gi] != T_MAX)) ?
                            et_reg[gi] + TIMER_W'(1) : et_reg[gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          et_reg[gi] <= '0;
        end else begin
          et_reg[gi] <= et_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ycnt_reg      <= '0;
      amber_idx_reg <= '0;
      foul_reg      <= '0;
      winner_reg    <= '0;
      fin_reg       <= '0;
      seen_low_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ycnt_reg      <= ycnt_next;
      amber_idx_reg <= amber_idx_next;
      foul_reg      <= foul_next;
      winner_reg    <= winner_next;
      fin_reg       <= fin_next;
      seen_low_reg  <= seen_low_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ycnt_next      = ycnt_reg;
    amber_idx_next = amber_idx_reg;
    foul_next      = foul_reg;
    winner_next    = winner_reg;
    seen_low_next  = seen_low_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && (bus.staged == 2'b11)) begin
          state_next     = AMBER;
          ycnt_next      = '0;
          amber_idx_next = 2'd1;
        end
      end

      AMBER: begin
        // Fouls latch even on the final amber edge; a double foul ends the race at once.
        foul_next = foul_reg | ~bus.staged;
        if (foul_next == 2'b11) begin
          state_next     = RESULT;
          amber_idx_next = '0;
          seen_low_next  = 1'b0;
        end else if (ycnt_reg == Y_LAST) begin
          ycnt_next = '0;
          if (amber_idx_reg == A_LAST) begin
            state_next     = RUN;
            amber_idx_next = '0;
          end else begin
            amber_idx_next = amber_idx_reg + 2'd1;
          end
        end else begin
          ycnt_next = ycnt_reg + YCW'(1);
        end
      end

      RUN: begin
        if (winner_reg == 2'b00) begin
          winner_next = fin_hit;
        end
        if ((&(foul_reg | fin_reg | fin_hit)) || (|tmo_hit)) begin
          state_next    = RESULT;
          seen_low_next = 1'b0;
        end
      end

      RESULT: begin
        if (!bus.start) begin
          seen_low_next = 1'b1;
        end
        if (clear_results) begin
          state_next    = IDLE;
          foul_next     = '0;
          winner_next   = '0;
          seen_low_next = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.red       = (state_reg == IDLE) || (state_reg == RESULT);
  assign bus.yellow    = (state_reg == AMBER);
  assign bus.green     = (state_reg == RUN);
  assign bus.done      = (state_reg == RESULT);
  assign bus.amber_idx = amber_idx_reg;
  assign bus.foul      = foul_reg;
  assign bus.winner    = winner_reg;
  assign bus.et0       = et_reg[0];
  assign bus.et1       = et_reg[1];
endmodule
